// File: rtl/mdu_div_ctrl_if.sv
// Request/result and hazard signals between the pipeline and the divide controller.
// The slave modport is the divider's view; the master modport is the pipeline's.
interface mdu_div_ctrl_if;
  logic        req_valid_in;
  logic        req_signed_in;
  logic [31:0] req_src1_in;
  logic [31:0] req_src2_in;
  logic        req_ready_out;
  logic        exe_valid_in;
  logic [5:0]  exe_mult_div_op_in;
  logic        div_stop_out;
  logic        div_complete_out;
  logic [63:0] div_res_out;
  logic        res_ack_in;
  logic        flush_in;

  modport slave (
    input  req_valid_in, req_signed_in, req_src1_in, req_src2_in,
    input  exe_valid_in, exe_mult_div_op_in, res_ack_in, flush_in,
    output req_ready_out, div_stop_out, div_complete_out, div_res_out
  );

  modport master (
    output req_valid_in, req_signed_in, req_src1_in, req_src2_in,
    output exe_valid_in, exe_mult_div_op_in, res_ack_in, flush_in,
    input  req_ready_out, div_stop_out, div_complete_out, div_res_out
  );
endinterface

// File: rtl/mdu_div_ctrl.sv
// Multi-cycle DIV/DIVU controller: restoring divide, one quotient bit per cycle,
// fixed 35-cycle latency, result held until the consumer acknowledges it.
module mdu_div_ctrl (
  input  logic           clk,
  input  logic           rst_n,
  mdu_div_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_cnt;
  logic [31:0] r_src1;
  logic [31:0] r_src2;
  logic        r_signed;
  logic [31:0] r_dvs;
  logic [31:0] r_quot;
  logic [32:0] r_rem;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div_zero;
  logic [63:0] r_res;

  logic        w_ack;
  logic        w_ready;
  logic        w_accept;
  logic [33:0] w_shift;
  logic [33:0] w_diff;
  logic        w_fits;

  assign w_ack    = bus.res_ack_in && (r_state == S_DONE);
  assign w_ready  = rst_n && !bus.flush_in && ((r_state == S_IDLE) || w_ack);
  assign w_accept = bus.req_valid_in && w_ready;

  // Quotient register doubles as the dividend shift register; a borrow means "does not fit".
  assign w_shift = {r_rem, r_quot[31]};
  assign w_diff  = w_shift - {2'b00, r_dvs};
  assign w_fits  = !w_diff[33];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_in) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_PREP;
        S_PREP:  w_state_nxt = S_RUN;
        S_RUN:   if (r_cnt == 6'd31) w_state_nxt = S_FIX;
        S_FIX:   w_state_nxt = S_DONE;
        S_DONE:  if (w_ack) w_state_nxt = w_accept ? S_PREP : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_signed   <= 1'b0;
      r_dvs      <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
      r_res      <= '0;
    end else begin
      if (w_accept) begin
        r_src1   <= bus.req_src1_in;
        r_src2   <= bus.req_src2_in;
        r_signed <= bus.req_signed_in;
      end
      case (r_state)
        S_PREP: begin
          r_quot     <= (r_signed && r_src1[31]) ? (32'd0 - r_src1) : r_src1;
          r_dvs      <= (r_signed && r_src2[31]) ? (32'd0 - r_src2) : r_src2;
          r_rem      <= '0;
          r_cnt      <= '0;
          r_q_neg    <= r_signed && (r_src1[31] ^ r_src2[31]);
          r_r_neg    <= r_signed && r_src1[31];
          r_div_zero <= (r_src2 == 32'd0);
        end
        S_RUN: begin
          r_rem  <= w_fits ? w_diff[32:0] : w_shift[32:0];
          r_quot <= {r_quot[30:0], w_fits};
          r_cnt  <= r_cnt + 6'd1;
        end
        S_FIX: begin
          // Divide by zero returns all-ones and the untouched dividend regardless of sign.
          if (r_div_zero)
            r_res <= {r_src1, 32'hFFFF_FFFF};
          else
            r_res <= {(r_r_neg ? (32'd0 - r_rem[31:0]) : r_rem[31:0]),
                      (r_q_neg ? (32'd0 - r_quot)      : r_quot)};
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_out    = w_ready;
  assign bus.div_complete_out = (r_state == S_DONE);
  assign bus.div_res_out      = (r_state == S_DONE) ? r_res : 64'd0;
  assign bus.div_stop_out     = bus.exe_valid_in && (|bus.exe_mult_div_op_in) &&
                                (r_state != S_IDLE) && !w_ack;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Self-checking bench for mdu_div_ctrl: directed corner cases plus randomized
// divides compared against an arithmetic reference model.
module tb_mdu_div_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mdu_div_ctrl_if bus ();

  mdu_div_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit exe_fixed = 1'b0;

  localparam logic [5:0] OP_MULT = 6'b000001;
  localparam logic [5:0] OP_MFLO = 6'b001000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_exe();
    if (exe_fixed) begin
      bus.exe_valid_in       = 1'b1;
      bus.exe_mult_div_op_in = OP_MFLO;
    end else begin
      bus.exe_valid_in       = 1'($urandom_range(0, 1));
      bus.exe_mult_div_op_in = 6'(1 << $urandom_range(0, 6));
    end
  endtask

  function automatic logic exp_busy_stop();
    return bus.exe_valid_in && (|bus.exe_mult_div_op_in);
  endfunction

  task automatic issue(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid_in  = 1'b1;
    bus.req_signed_in = sgn;
    bus.req_src1_in   = a;
    bus.req_src2_in   = b;
  endtask

  task automatic scramble_req();
    bus.req_valid_in  = 1'b0;
    bus.req_signed_in = 1'($urandom_range(0, 1));
    bus.req_src1_in   = $urandom;
    bus.req_src2_in   = $urandom;
  endtask

  task automatic accept_edge(input string tag);
    #1;
    check({tag, "_acc_ready"}, 64'(bus.req_ready_out), 64'd1);
    tick();
    scramble_req();
  endtask

  // Entered in the first cycle after the accept edge; ends after the ack edge.
  task automatic finish_one(input string tag, input logic [63:0] exp, input int hold,
                            input bit chain, input bit nsgn, input logic [31:0] na,
                            input logic [31:0] nb);
    int cyc = 1;
    bus.res_ack_in = 1'b0;
    rand_exe();
    #1;
    while (!bus.div_complete_out && cyc < 60) begin
      check({tag, "_res_zero"}, bus.div_res_out, 64'd0);
      check({tag, "_stop_busy"}, 64'(bus.div_stop_out), 64'(exp_busy_stop()));
      bus.res_ack_in = 1'($urandom_range(0, 1));
      tick();
      bus.res_ack_in = 1'b0;
      rand_exe();
      #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'd35);
    check({tag, "_result"}, bus.div_res_out, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      rand_exe();
      #1;
      check({tag, "_hold_cmp"}, 64'(bus.div_complete_out), 64'd1);
      check({tag, "_hold_res"}, bus.div_res_out, exp);
      check({tag, "_hold_stop"}, 64'(bus.div_stop_out), 64'(exp_busy_stop()));
    end
    bus.res_ack_in = 1'b1;
    if (chain) issue(nsgn, na, nb);
    #1;
    check({tag, "_ack_stop"}, 64'(bus.div_stop_out), 64'd0);
    check({tag, "_ack_ready"}, 64'(bus.req_ready_out), 64'd1);
    tick();
    bus.res_ack_in = 1'b0;
    scramble_req();
    if (!chain) begin
      #1;
      check({tag, "_post_cmp"}, 64'(bus.div_complete_out), 64'd0);
      check({tag, "_post_ready"}, 64'(bus.req_ready_out), 64'd1);
      check({tag, "_post_stop"}, 64'(bus.div_stop_out), 64'd0);
    end
  endtask

  task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int hold);
    issue(sgn, a, b);
    accept_edge(tag);
    finish_one(tag, exp, hold, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic watch_no_complete(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.div_complete_out) seen = 1'b1;
      tick();
    end
    check({tag, "_no_complete"}, 64'(seen), 64'd0);
  endtask

  initial begin
    bus.req_valid_in       = 1'b0;
    bus.req_signed_in      = 1'b0;
    bus.req_src1_in        = '0;
    bus.req_src2_in        = '0;
    bus.exe_valid_in       = 1'b1;
    bus.exe_mult_div_op_in = OP_MFLO;
    bus.res_ack_in         = 1'b0;
    bus.flush_in           = 1'b0;

    #3;
    check("rst_complete", 64'(bus.div_complete_out), 64'd0);
    check("rst_stop", 64'(bus.div_stop_out), 64'd0);
    check("rst_res", bus.div_res_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 64'(bus.req_ready_out), 64'd1);
    check("idle_mflo_stop", 64'(bus.div_stop_out), 64'd0);

    exe_fixed = 1'b1;
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 3);
    exe_fixed = 1'b0;
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD}, 1);
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 2);
    run_div("divu_zero", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1);
    run_div("div_zero_neg", 1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 0);

    // Back-to-back: ack and new request on the same edge.
    issue(1'b0, 32'd1000, 32'd33);
    accept_edge("b2b_a");
    finish_one("b2b_a", ref_div(1'b0, 32'd1000, 32'd33), 1, 1'b1, 1'b1, 32'hFFFF_FC18, 32'd7);
    finish_one("b2b_b", ref_div(1'b1, 32'hFFFF_FC18, 32'd7), 0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Flush during RUN iteration 10 (cycle 12 after accept).
    issue(1'b0, 32'hDEAD_BEEF, 32'd3);
    accept_edge("flush_run");
    for (int i = 0; i < 11; i++) tick();
    bus.flush_in = 1'b1;
    #1;
    check("flush_run_ready_low", 64'(bus.req_ready_out), 64'd0);
    tick();
    bus.flush_in = 1'b0;
    #1;
    check("flush_run_cmp", 64'(bus.div_complete_out), 64'd0);
    check("flush_run_ready", 64'(bus.req_ready_out), 64'd1);
    watch_no_complete("flush_run", 45);

    // Flush together with a request: not accepted.
    issue(1'b0, 32'd50, 32'd5);
    bus.flush_in = 1'b1;
    #1;
    check("flush_req_ready", 64'(bus.req_ready_out), 64'd0);
    tick();
    scramble_req();
    bus.flush_in           = 1'b0;
    bus.exe_valid_in       = 1'b1;
    bus.exe_mult_div_op_in = OP_MULT;
    #1;
    check("flush_req_stop", 64'(bus.div_stop_out), 64'd0);
    watch_no_complete("flush_req", 40);

    // Async reset mid-RUN.
    issue(1'b1, 32'h0123_4567, 32'hFFFF_FF00);
    accept_edge("rst_run");
    for (int i = 0; i < 15; i++) tick();
    bus.exe_valid_in       = 1'b1;
    bus.exe_mult_div_op_in = OP_MFLO;
    rst_n = 1'b0;
    #1;
    check("rst_run_cmp", 64'(bus.div_complete_out), 64'd0);
    check("rst_run_stop", 64'(bus.div_stop_out), 64'd0);
    check("rst_run_res", bus.div_res_out, 64'd0);
    check("rst_run_ready", 64'(bus.req_ready_out), 64'd0);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_run_ready_rel", 64'(bus.req_ready_out), 64'd1);
    watch_no_complete("rst_run", 45);

    // Randomized divides, some chained.
    begin
      bit          sgn = 1'($urandom_range(0, 1));
      logic [31:0] a = rand_operand();
      logic [31:0] b = rand_operand();
      issue(sgn, a, b);
      accept_edge("rnd");
      for (int n = 0; n < 40; n++) begin
        bit          chain = (n != 39) && ($urandom_range(0, 1) == 1);
        bit          nsgn = 1'($urandom_range(0, 1));
        logic [31:0] na = rand_operand();
        logic [31:0] nb = rand_operand();
        finish_one($sformatf("rnd%0d", n), ref_div(sgn, a, b), $urandom_range(0, 3),
                   chain, nsgn, na, nb);
        sgn = nsgn;
        a = na;
        b = nb;
        if (!chain && n != 39) begin
          issue(sgn, a, b);
          accept_edge($sformatf("rnd%0d", n + 1));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mdu_div_ctrl.md
MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have the remaining ports:
  - req_valid_in  in  1  a DIV/DIVU request is offered this cycle.
  - req_signed_in  in  1  1 = DIV (signed), 0 = DIVU.
  - req_src1_in  in  32  dividend.
  - req_src2_in  in  32  divisor.
  - req_ready_out  out  1  request accepted at this edge if req_valid_in=1.
  - exe_valid_in  in  1  EXE stage holds a valid instruction.
  - exe_mult_div_op_in  in  6  one-hot {0:MULT,1:DIV,2:MFHI,3:MFLO,4:MTHI,5:MTLO}.
  - div_stop_out  out  1  EXE instruction must stall for the pending divide.
  - div_complete_out  out  1  div_res_out is valid.
  - div_res_out  out  64  {remainder (HI), quotient (LO)}.
  - res_ack_in  in  1  consumer has written HI/LO this edge.
  - flush_in  in  1  pipeline clear (exception/eret); cancels the divide.

Function
REQ-003 SHALL implement an FSM with states IDLE, PREP, RUN, FIX, DONE.
REQ-004 SHALL drive req_ready_out = (state==IDLE) || (state==DONE && res_ack_in) while flush_in=0, and req_ready_out=0 while flush_in=1.
REQ-005 SHALL accept a request at an edge where req_valid_in && req_ready_out, latching src1, src2 and signed at that edge; later input changes have no effect on the result.
REQ-006 SHALL go to PREP on accept; in PREP, SHALL take absolute values when signed, record quotient sign (src1[31]^src2[31]) and remainder sign (src1[31]), and detect divisor==0.
REQ-007 SHALL perform a restoring divide in RUN: one quotient bit per cycle, 6-bit iteration counter from 0 to 31, exactly 32 RUN cycles, 33-bit partial remainder.
REQ-008 In FIX (1 cycle), SHALL negate the quotient and remainder (two's complement) per the recorded signs when signed, then enter DONE.
REQ-009 Latency: div_complete_out SHALL first be 1 in the 35th cycle after the accept edge (PREP 1 + RUN 32 + FIX 1), independent of operand values.
REQ-010 In DONE, SHALL hold div_complete_out=1 and div_res_out stable until res_ack_in=1, then go to IDLE, or to PREP if a new request is accepted at the same edge.
REQ-011 res_ack_in outside DONE SHALL be ignored.
REQ-012 Divisor zero SHALL give quotient 0xFFFFFFFF and remainder = the original dividend, with full latency and no trap.
REQ-013 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-014 SHALL drive div_stop_out = exe_valid_in && |exe_mult_div_op_in && state!=IDLE && !(state==DONE && res_ack_in), so that HI/LO readers and writers are serialized behind the divide.
REQ-015 On flush_in=1 at an edge, SHALL go to IDLE from any state and discard the result; flush_in has priority over req_valid_in and res_ack_in.
REQ-016 In the cycle after a flush, div_complete_out SHALL be 0.
REQ-017 div_res_out SHALL be 0 whenever the state is not DONE.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, counter 0, and all internal operand/remainder registers 0.
REQ-019 During and after reset, outputs SHALL be: div_complete_out=0, div_stop_out=0, div_res_out=0, and req_ready_out=1 once rst_n=1 with flush_in=0.
REQ-020 Reset asserted mid-RUN SHALL abort the divide with no residual completion after release.

Verification
REQ-021 Unsigned divide: DIVU 100/7 -> complete on the 35th cycle, res={0x00000002, 0x0000000E}; held until ack, IDLE the cycle after ack.
REQ-022 Signed divides:
  - DIV 7/-2 -> {0x00000001, 0xFFFFFFFD}.
  - DIV -7/2 -> {0xFFFFFFFF, 0xFFFFFFFD}.
  - DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}.
REQ-023 Divide by zero: DIVU 0x1234/0 -> {0x00001234, 0xFFFFFFFF} on the 35th cycle.
REQ-024 Hazard stall: MFLO in EXE with exe_valid_in=1 during RUN -> div_stop_out=1 every cycle until the ack edge, then 0; MFLO in EXE with state IDLE -> div_stop_out=0.
REQ-025 Flush and reset abort:
  - flush_in pulse in RUN iteration 10 -> IDLE next cycle, div_complete_out never asserts, req_ready_out=1.
  - flush_in together with req_valid_in -> request not accepted.
REQ-026 Back-to-back requests: ack and new request at the same DONE edge -> second result completes 35 cycles later; async rst_n low mid-RUN -> all outputs 0 immediately.
